ifu_fetch: RTL and testbench

Instruction fetch stage of the single-issue RV64 core; sits directly upstream of the decode stage and feeds it one 32-bit instruction plus its PC per handshake. Owns the architectural fetch PC, issues word reads to instruction memory over a valid/ready request channel, captures the response, and holds it until decode accepts. Accepts redirects (branch/jump/trap targets) from the execute stage at any time and squashes in-flight work.

---
 rtl/ifu_fetch.sv | 153 +++++++++++++++
 tb/tb_ifu_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch - instruction fetch stage of the single-issue RV64 core.
//
// Owns the architectural fetch PC, issues one word read at a time to
// instruction memory, captures the response and holds it until decode
// accepts it. Redirects from execute may arrive in any cycle and squash
// whatever fetch is in flight.
//
// Ports:
//   clk             in   clock, all state updates on the rising edge
//   rst             in   synchronous reset, active-low
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_req_addr   out  fetch address (word aligned)
//   imem_rsp_valid  in   response data valid
//   imem_rsp_data   in   fetched instruction word
//   redirect_valid  in   one-cycle pulse: refetch from redirect_pc
//   redirect_pc     in   redirect target
//   inst_valid      out  instruction available to decode
//   inst_ready      in   decode accepts the instruction
//   inst            out  instruction word
//   inst_pc         out  PC of inst
//   misalign_err    out  sticky misaligned-redirect flag
//
// Build option:
//   IFU_MISALIGN_CHK_EN - when defined, a redirect whose target has
//   bits [1:0] != 0 sets misalign_err and parks the stage in HALT until
//   reset. When undefined, the low target bits are silently dropped and
//   misalign_err is tied low.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3
`ifdef IFU_MISALIGN_CHK_EN
        ,
        S_HALT = 3'd4
`endif
    } state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [31:0] inst_q;
    logic [63:0] inst_pc_q;
    logic        kill_q;    // the outstanding response belongs to a squashed fetch
    logic [63:0] redirect_tgt;

    // Low two bits of the target are always forced to zero.
    assign redirect_tgt = redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;

`ifdef IFU_MISALIGN_CHK_EN
    logic err_q;
    logic misalign_hit;

    assign misalign_hit = redirect_valid && (redirect_pc[1:0] != 2'b00) &&
                          (state_q != S_HALT);
    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            inst_pc_q <= 64'h0;
            kill_q    <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
            err_q     <= 1'b0;
        end else if (misalign_hit) begin
            // Misaligned target wins over every other event.
            state_q   <= S_HALT;
            err_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_BOOT: begin
                    if (redirect_valid) pc_q <= redirect_tgt;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (redirect_valid) pc_q <= redirect_tgt;
                    if (imem_req_ready) begin
                        state_q <= S_WAIT;
                        // A redirect in the accept cycle makes the fetch stale.
                        kill_q  <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) pc_q <= redirect_tgt;
                    if (imem_rsp_valid) begin
                        kill_q <= 1'b0;
                        if (redirect_valid || kill_q) begin
                            state_q <= S_REQ;
                        end else begin
                            inst_q    <= imem_rsp_data;
                            inst_pc_q <= pc_q;
                            state_q   <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A handshake in the redirect cycle still delivers the
                    // instruction, but the next fetch goes to the target.
                    if (redirect_valid) begin
                        pc_q    <= redirect_tgt;
                        state_q <= S_REQ;
                    end else if (inst_ready) begin
                        pc_q    <= pc_q + 64'd4;
                        state_q <= S_REQ;
                    end
                end
`ifdef IFU_MISALIGN_CHK_EN
                S_HALT: begin
                    state_q <= S_HALT;
                end
`endif
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    // All outputs come straight from registered state.
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        misalign_err;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the decode side against the
    // scoreboard, then advance to 1 time unit after the next rising edge.
    task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rd,
                       input bit ir, input bit redir, input logic [63:0] rpc);
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        inst_ready     = ir;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (sb.size() == 0) begin
            chk("no_spurious_inst", {63'h0, inst_valid}, 64'h0);
        end else if (inst_valid) begin
            chk("inst", {32'h0, inst}, {32'h0, sb[0].ins});
            chk("inst_pc", inst_pc, sb[0].pc);
            if (ir) void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    // One unobstructed fetch: request accepted at once, response the
    // following cycle, decode accepts as soon as the instruction appears.
    task automatic fetch(input logic [63:0] a, input logic [31:0] d);
        item_t it;
        chk("req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("req_addr", imem_req_addr, a);
        chk("req_inst_valid", {63'h0, inst_valid}, 64'h0);
        cyc(1, 0, 0, 0, 0, 64'h0);
        chk("wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("wait_inst_valid", {63'h0, inst_valid}, 64'h0);
        it.pc  = a;
        it.ins = d;
        sb.push_back(it);
        cyc(0, 1, d, 0, 0, 64'h0);
        chk("hold_inst_valid", {63'h0, inst_valid}, 64'h1);
        chk("hold_req_valid", {63'h0, imem_req_valid}, 64'h0);
        cyc(0, 0, 0, 1, 0, 64'h0);
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        inst_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst_inst", {32'h0, inst}, 64'h0);
        chk("rst_inst_pc", inst_pc, 64'h0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_misalign", {63'h0, misalign_err}, 64'h0);

        rst = 1'b1;
        chk("boot_req_valid", {63'h0, imem_req_valid}, 64'h0);
        cyc(0, 0, 0, 0, 0, 64'h0);

        // Back-to-back sequential fetches
        fetch(64'h8000_0000, 32'h0000_0413);
        fetch(64'h8000_0004, 32'h0010_0493);
        fetch(64'h8000_0008, 32'h0020_0513);

        // Decode stalls for 5 cycles in HOLD
        chk("s_req_addr", imem_req_addr, 64'h8000_000C);
        cyc(1, 0, 0, 0, 0, 64'h0);
        sb.push_back({64'h8000_000C, 32'h0030_0593});
        cyc(0, 1, 32'h0030_0593, 0, 0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_inst_valid", {63'h0, inst_valid}, 64'h1);
            chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
            chk("stall_pc", imem_req_addr, 64'h8000_000C);
            cyc(0, 0, 0, 0, 0, 64'h0);
        end
        cyc(0, 0, 0, 1, 0, 64'h0);

        // Redirect coinciding with the HOLD handshake at 0x80000010
        chk("hr_req_addr", imem_req_addr, 64'h8000_0010);
        cyc(1, 0, 0, 0, 0, 64'h0);
        sb.push_back({64'h8000_0010, 32'h0040_0613});
        cyc(0, 1, 32'h0040_0613, 0, 0, 64'h0);
        cyc(0, 0, 0, 1, 1, 64'h8000_0100);
        chk("hr_next_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("hr_next_addr", imem_req_addr, 64'h8000_0100);

        // Memory not ready for 4 cycles, then redirect during the stall
        for (int i = 0; i < 4; i++) begin
            chk("rs_req_valid", {63'h0, imem_req_valid}, 64'h1);
            chk("rs_req_addr", imem_req_addr, 64'h8000_0100);
            cyc(0, 0, 0, 0, 0, 64'h0);
        end
        cyc(0, 0, 0, 0, 1, 64'h8000_1000);
        chk("rs_redir_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("rs_redir_addr", imem_req_addr, 64'h8000_1000);
        fetch(64'h8000_1000, 32'h0050_0693);

        // Redirect in WAIT, stale response two cycles later
        chk("w_req_addr", imem_req_addr, 64'h8000_1004);
        cyc(1, 0, 0, 0, 0, 64'h0);
        cyc(0, 0, 0, 0, 1, 64'h8000_2000);
        chk("w_kill_req_valid", {63'h0, imem_req_valid}, 64'h0);
        cyc(0, 0, 0, 0, 0, 64'h0);
        chk("w_kill_req_valid2", {63'h0, imem_req_valid}, 64'h0);
        cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 64'h0);
        cyc(0, 0, 0, 1, 0, 64'h0);
        fetch(64'h8000_2000, 32'h0060_0713);

        // Redirect in the same cycle the request is accepted
        chk("ra_req_addr", imem_req_addr, 64'h8000_2004);
        cyc(1, 0, 0, 0, 1, 64'h8000_3000);
        chk("ra_wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
        cyc(0, 1, 32'h1111_1111, 1, 0, 64'h0);
        chk("ra_after_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("ra_after_addr", imem_req_addr, 64'h8000_3000);

        // Redirect in the same cycle the response arrives
        cyc(1, 0, 0, 0, 0, 64'h0);
        cyc(0, 1, 32'h2222_2222, 1, 1, 64'h8000_4000);
        chk("rr_after_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("rr_after_addr", imem_req_addr, 64'h8000_4000);
        fetch(64'h8000_4000, 32'h0070_0793);

        // PC wraps past the top of the address space
        cyc(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0080_0813);
        chk("wrap_addr", imem_req_addr, 64'h0);

        // Misaligned redirect target
        cyc(0, 0, 0, 0, 1, 64'h8000_0002);
`ifdef IFU_MISALIGN_CHK_EN
        chk("mis_err", {63'h0, misalign_err}, 64'h1);
        chk("mis_req_valid", {63'h0, imem_req_valid}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 32'h6666_6666, 1, 1, 64'h8000_0000);
            chk("halt_req_valid", {63'h0, imem_req_valid}, 64'h0);
            chk("halt_inst_valid", {63'h0, inst_valid}, 64'h0);
            chk("halt_err", {63'h0, misalign_err}, 64'h1);
        end
`else
        chk("mis_err", {63'h0, misalign_err}, 64'h0);
        chk("mis_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("mis_req_addr", imem_req_addr, 64'h8000_0000);
`endif

        // Reset mid-operation; stale responses afterwards are ignored
        cyc(1, 0, 0, 0, 0, 64'h0);
        rst = 1'b0;
        cyc(0, 1, 32'h3333_3333, 0, 0, 64'h0);
        chk("mid_rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("mid_rst_addr", imem_req_addr, RST_PC);
        chk("mid_rst_misalign", {63'h0, misalign_err}, 64'h0);
        chk("mid_rst_inst", {32'h0, inst}, 64'h0);
        rst = 1'b1;
        cyc(0, 1, 32'h4444_4444, 1, 0, 64'h0);
        chk("post_rst_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("post_rst_addr", imem_req_addr, RST_PC);
        cyc(0, 1, 32'h5555_5555, 1, 0, 64'h0);
        chk("post_rst_req_valid2", {63'h0, imem_req_valid}, 64'h1);
        chk("post_rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        cyc(0, 0, 0, 0, 0, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
